instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited memory requests, in-order address FIFO, and an instruction queue toward decode.
// Optional macro IF_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module instr_fetch #(
    parameter int QDEPTH = 2
) (
    input  logic        IF_clk,
    input  logic        IF_rst,
    input  logic [31:0] IF_pc,
    input  logic        IF_flush,
    output logic        IF_imem_req,
    output logic [31:0] IF_imem_addr,
    input  logic        IF_imem_gnt,
    input  logic        IF_imem_rvalid,
    input  logic [31:0] IF_imem_rdata,
    output logic        IF_out_valid,
    output logic [31:0] IF_out_instr,
    output logic [31:0] IF_out_pc,
    input  logic        IF_out_ready,
    output logic        IF_pc_hold
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QDEPTH);

    logic [31:0]   addr_mem [QDEPTH];
    logic [PW-1:0] addr_wp, addr_rp;

    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] q_wp, q_rp;
    logic [CW-1:0] q_cnt;

    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;

    logic [CW:0]   used;
    logic          accept, rsp, rsp_keep, bypass, q_empty, q_push, q_pop;
    logic [31:0]   rsp_pc;

    // Credits cover both outstanding fetches and queued words, so every response always has a slot.
    assign used         = {1'b0, inflight} + {1'b0, q_cnt};
    assign IF_imem_req  = !IF_rst && !IF_flush && (used < DEPTH_W);
    assign IF_imem_addr = IF_pc;
    assign accept       = IF_imem_req && IF_imem_gnt;
    assign IF_pc_hold   = !accept;

    assign rsp      = IF_imem_rvalid && (inflight != '0);
    assign rsp_pc   = addr_mem[addr_rp];
    assign rsp_keep = rsp && !IF_flush && (discard == '0);
    assign q_empty  = (q_cnt == '0);

`ifdef IF_BYPASS_EN
    assign bypass = rsp_keep && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign IF_out_valid = !IF_rst && !IF_flush && (!q_empty || bypass);
    assign q_pop        = IF_out_valid && IF_out_ready && !q_empty;
    assign q_push       = rsp_keep && !(bypass && IF_out_ready);

    always_comb begin
        IF_out_instr = '0;
        IF_out_pc    = '0;
        if (!IF_rst) begin
            if (!q_empty) begin
                IF_out_instr = q_instr[q_rp];
                IF_out_pc    = q_pc[q_rp];
            end else if (bypass) begin
                IF_out_instr = IF_imem_rdata;
                IF_out_pc    = rsp_pc;
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts define what is valid, so reset only those.
    always_ff @(posedge IF_clk) begin
        if (accept) begin
            addr_mem[addr_wp] <= IF_pc;
        end
        if (q_push) begin
            q_instr[q_wp] <= IF_imem_rdata;
            q_pc[q_wp]    <= rsp_pc;
        end
    end

    always_ff @(posedge IF_clk) begin
        if (IF_rst) begin
            addr_wp  <= '0;
            addr_rp  <= '0;
            q_wp     <= '0;
            q_rp     <= '0;
            q_cnt    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else begin
            if (accept) addr_wp <= addr_wp + PW'(1);
            if (rsp)    addr_rp <= addr_rp + PW'(1);
            inflight <= inflight + CW'(accept) - CW'(rsp);

            // A flush turns every fetch still outstanding after this cycle into one to drop.
            if (IF_flush) begin
                discard <= inflight - CW'(rsp);
                q_wp    <= '0;
                q_rp    <= '0;
                q_cnt   <= '0;
            end else begin
                if (rsp && (discard != '0)) discard <= discard - CW'(1);
                if (q_push) q_wp <= q_wp + PW'(1);
                if (q_pop)  q_rp <= q_rp + PW'(1);
                q_cnt <= q_cnt + CW'(q_push) - CW'(q_pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a directed cycle table for the corner cases, then randomized traffic
// against a queue-based reference model and an in-order memory model (honours IF_BYPASS_EN).
module tb_instr_fetch;

    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush, req, gnt, rvalid, out_valid, ready, hold;
    logic [31:0] pc, addr, rdata, out_instr, out_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch #(.QDEPTH(QDEPTH)) dut (
        .IF_clk(clk), .IF_rst(rst), .IF_pc(pc), .IF_flush(flush),
        .IF_imem_req(req), .IF_imem_addr(addr), .IF_imem_gnt(gnt),
        .IF_imem_rvalid(rvalid), .IF_imem_rdata(rdata),
        .IF_out_valid(out_valid), .IF_out_instr(out_instr), .IF_out_pc(out_pc),
        .IF_out_ready(ready), .IF_pc_hold(hold)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'h5EED_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, flush;
        logic [31:0] pc;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req, e_hold, e_valid;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic f, input logic [31:0] p, input logic g,
                                input logic rv, input logic [31:0] ra, input logic rd,
                                input logic eq, input logic eh, input logic ev, input logic [31:0] opc);
        vec_t v;
        v.rst = r; v.flush = f; v.pc = p; v.gnt = g; v.rvalid = rv; v.rdata = imem(ra);
        v.ready = rd; v.e_req = eq; v.e_hold = eh; v.e_valid = ev;
        v.e_pc    = ev ? opc : 32'h0;
        v.e_instr = ev ? imem(opc) : 32'h0;
        return v;
    endfunction

    task automatic apply_row(input vec_t v, input int idx);
        rst = v.rst; flush = v.flush; pc = v.pc; gnt = v.gnt;
        rvalid = v.rvalid; rdata = v.rdata; ready = v.ready;
        #3;
        check($sformatf("row%0d req", idx), 32'(req), 32'(v.e_req));
        check($sformatf("row%0d hold", idx), 32'(hold), 32'(v.e_hold));
        check($sformatf("row%0d valid", idx), 32'(out_valid), 32'(v.e_valid));
        check($sformatf("row%0d addr", idx), addr, v.pc);
        if (v.e_valid || v.rst) begin
            check($sformatf("row%0d out_pc", idx), out_pc, v.e_pc);
            check($sformatf("row%0d out_instr", idx), out_instr, v.e_instr);
        end
        @(posedge clk); #1;
    endtask

    typedef struct { logic [31:0] addr; bit disc; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } qent_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    infl_t   m_infl[$];
    qent_t   m_q[$];
    memreq_t mem_q[$];

    initial begin
        logic [31:0] cur_pc, e_pc, e_instr;
        logic        r_rst, r_flush, m_rsp, e_req, e_hold, e_valid, byp;
        infl_t       hd;

        rst = 1'b1; flush = 1'b0; pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
        @(posedge clk); #1;

`ifndef IF_BYPASS_EN
        // Straight-line fetch 0,4,8 with one-cycle memory; reset while a word is still queued.
        tbl.push_back(mk(1,0,32'h00,1,0,0,1, 0,1,0,0));
        tbl.push_back(mk(0,0,32'h00,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h04,1,1,32'h00,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h08,1,1,32'h04,1, 0,1,1,32'h00));
        tbl.push_back(mk(0,0,32'h08,1,0,0,1, 1,0,1,32'h04));
        tbl.push_back(mk(0,0,32'h0C,1,1,32'h08,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h10,1,1,32'h0C,1, 0,1,1,32'h08));
        tbl.push_back(mk(1,0,32'h10,1,0,0,1, 0,1,0,0));
        // Grant withheld for three cycles.
        tbl.push_back(mk(0,0,32'h40,0,0,0,1, 1,1,0,0));
        tbl.push_back(mk(0,0,32'h40,0,0,0,1, 1,1,0,0));
        tbl.push_back(mk(0,0,32'h40,0,0,0,1, 1,1,0,0));
        tbl.push_back(mk(0,0,32'h40,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h44,0,1,32'h40,1, 1,1,0,0));
        tbl.push_back(mk(0,0,32'h44,0,0,0,1, 1,1,1,32'h40));
        tbl.push_back(mk(1,0,32'h00,1,0,0,1, 0,1,0,0));
        // Decode stalled: credits run out, then drain without loss.
        tbl.push_back(mk(0,0,32'h00,1,0,0,0, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h04,1,1,32'h00,0, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h08,1,1,32'h04,0, 0,1,1,32'h00));
        tbl.push_back(mk(0,0,32'h08,1,0,0,0, 0,1,1,32'h00));
        tbl.push_back(mk(0,0,32'h08,1,0,0,1, 0,1,1,32'h00));
        tbl.push_back(mk(0,0,32'h08,1,0,0,1, 1,0,1,32'h04));
        tbl.push_back(mk(0,0,32'h0C,1,1,32'h08,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h10,1,1,32'h0C,1, 0,1,1,32'h08));
        tbl.push_back(mk(0,0,32'h10,1,0,0,1, 1,0,1,32'h0C));
        tbl.push_back(mk(1,0,32'h00,1,0,0,1, 0,1,0,0));
        // Flush with two fetches outstanding.
        tbl.push_back(mk(0,0,32'h10,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h14,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,1,32'h80,1,0,0,1, 0,1,0,0));
        tbl.push_back(mk(0,0,32'h80,1,1,32'h10,1, 0,1,0,0));
        tbl.push_back(mk(0,0,32'h80,1,1,32'h14,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h84,1,1,32'h80,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h88,1,0,0,1, 0,1,1,32'h80));
        tbl.push_back(mk(0,0,32'h88,1,1,32'h84,1, 1,0,0,0));
        tbl.push_back(mk(1,0,32'h00,1,0,0,1, 0,1,0,0));
        // Flush coinciding with the first response.
        tbl.push_back(mk(0,0,32'h10,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h14,1,0,0,1, 1,0,0,0));
        tbl.push_back(mk(0,1,32'h80,1,1,32'h10,1, 0,1,0,0));
        tbl.push_back(mk(0,0,32'h80,1,1,32'h14,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h84,1,1,32'h80,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h88,1,0,0,1, 0,1,1,32'h80));
        tbl.push_back(mk(0,0,32'h88,1,1,32'h84,1, 1,0,0,0));
        tbl.push_back(mk(0,0,32'h8C,1,1,32'h88,1, 0,1,1,32'h84));
        tbl.push_back(mk(1,0,32'h00,1,0,0,1, 0,1,0,0));
        // Stray response with nothing outstanding.
        tbl.push_back(mk(0,0,32'h20,0,1,32'h99,1, 1,1,0,0));
        tbl.push_back(mk(0,0,32'h20,0,0,0,1, 1,1,0,0));

        foreach (tbl[i]) apply_row(tbl[i], i);
`endif

        cur_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            r_rst   = (c == 0) || ($urandom_range(0, 199) == 0);
            r_flush = !r_rst && ($urandom_range(0, 11) == 0);
            if (r_flush) cur_pc = $urandom & 32'hFFFF_FFFC;
            gnt    = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 9) < 7);
            rvalid = 1'b0;
            rdata  = $urandom;
            if (mem_q.size() > 0) begin
                if (mem_q[0].due <= c && $urandom_range(0, 4) != 0) begin
                    rvalid = 1'b1;
                    rdata  = imem(mem_q[0].addr);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                rvalid = 1'b1;
            end
            rst = r_rst; flush = r_flush; pc = cur_pc;

            m_rsp  = rvalid && (m_infl.size() > 0) && !r_rst;
            e_req  = !r_rst && !r_flush && ((m_infl.size() + m_q.size()) < QDEPTH);
            e_hold = !(e_req && gnt);
            byp    = 1'b0;
`ifdef IF_BYPASS_EN
            byp = m_rsp && !r_flush && !m_infl[0].disc && (m_q.size() == 0);
`endif
            e_valid = !r_rst && !r_flush && ((m_q.size() > 0) || byp);
            e_pc = '0; e_instr = '0;
            if (e_valid) begin
                if (m_q.size() > 0) begin
                    e_pc = m_q[0].pc; e_instr = m_q[0].instr;
                end else begin
                    e_pc = m_infl[0].addr; e_instr = rdata;
                end
            end

            #3;
            check($sformatf("rnd%0d req", c), 32'(req), 32'(e_req));
            check($sformatf("rnd%0d hold", c), 32'(hold), 32'(e_hold));
            check($sformatf("rnd%0d valid", c), 32'(out_valid), 32'(e_valid));
            check($sformatf("rnd%0d addr", c), addr, cur_pc);
            if (e_valid || r_rst) begin
                check($sformatf("rnd%0d out_pc", c), out_pc, e_pc);
                check($sformatf("rnd%0d out_instr", c), out_instr, e_instr);
            end

            if (r_rst) begin
                m_infl.delete(); m_q.delete(); mem_q.delete();
            end else begin
                if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
                if (e_valid && ready && m_q.size() > 0) void'(m_q.pop_front());
                if (m_rsp) begin
                    hd = m_infl.pop_front();
                    if (!r_flush && !hd.disc && !(byp && ready)) m_q.push_back('{hd.addr, rdata});
                end
                if (r_flush) begin
                    m_q.delete();
                    foreach (m_infl[i]) m_infl[i].disc = 1'b1;
                end
                if (e_req && gnt) begin
                    m_infl.push_back('{cur_pc, 1'b0});
                    mem_q.push_back('{cur_pc, c + int'($urandom_range(1, 3))});
                    cur_pc = cur_pc + 32'd4;
                end
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
